load_store_unit: RTL and testbench

//  Initiator side of the DataMemory port (Address/WriteData/MemWrite/MemRead/ReadData).

---
 rtl/load_store_unit_pkg.sv | 33 +++
 rtl/lsu_lane_align.sv | 41 ++++
 rtl/load_store_unit.sv | 137 +++++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit.
// Access sizes and FSM states used by the top and the lane aligner.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ERR     = 3'd1,
        LOAD    = 3'd2,
        ST_WORD = 3'd3,
        RMW_RD  = 3'd4,
        RMW_WR  = 3'd5
    } state_e;

    // True when the access does not fit its natural alignment.
    function automatic logic misaligned(size_e sz, logic [1:0] off);
        logic bad;
        bad = 1'b0;
        unique case (1'b1)
            (sz == SIZE_HALF): bad = off[0];
            (sz == SIZE_WORD): bad = (off != 2'b00);
            default:           bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract/extend for loads
// and sub-word merge into a read word for stores.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  size_e       size_i,
    input  logic        signed_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_val_o,
    output logic [31:0] merged_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed lane, extend it, and build the merged word.
    always_comb begin
        lane_b     = word_i[{offset_i, 3'b000} +: 8];
        lane_h     = offset_i[1] ? word_i[31:16] : word_i[15:0];
        load_val_o = word_i;
        merged_o   = word_i;
        unique case (size_i)
            SIZE_BYTE: begin
                load_val_o = {{24{signed_i & lane_b[7]}}, lane_b};
                merged_o[{offset_i, 3'b000} +: 8] = store_data_i[7:0];
            end
            SIZE_HALF: begin
                load_val_o = {{16{signed_i & lane_h[15]}}, lane_h};
                if (offset_i[1]) merged_o[31:16] = store_data_i[15:0];
                else             merged_o[15:0]  = store_data_i[15:0];
            end
            default: begin
                load_val_o = word_i;
                merged_o   = store_data_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into word-aligned
// DataMemory cycles, using read-modify-write for sub-word stores.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter bit          CHECK_RANGE = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        IsStore,
    input  logic [1:0]  Size,
    input  logic        Signed,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Ready,
    output logic        Done,
    output logic        Err,
    output logic [31:0] LoadData,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] MemReadData
);

    localparam logic [32:0] MemBytes = 33'(MEM_WORDS) << 2;

    state_e      state_q;
    logic [1:0]  off_q;
    size_e       size_q;
    logic        signed_q;
    logic [31:0] sdata_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] ldata_q;
    logic [31:0] maddr_q;
    logic [31:0] mwdata_q;

    size_e       req_size;
    logic        out_range;
    logic        req_err;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign req_size  = size_e'(Size);
    assign out_range = CHECK_RANGE && ({1'b0, Addr} >= MemBytes);
    assign req_err   = misaligned(req_size, Addr[1:0])
                     | (req_size == SIZE_RSVD)
                     | out_range;

    lsu_lane_align u_align (
        .word_i       (MemReadData),
        .offset_i     (off_q),
        .size_i       (size_q),
        .signed_i     (signed_q),
        .store_data_i (sdata_q),
        .load_val_o   (load_val),
        .merged_o     (merged)
    );

    // Request FSM with input latches and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            off_q    <= 2'b00;
            size_q   <= SIZE_BYTE;
            signed_q <= 1'b0;
            sdata_q  <= 32'h0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ldata_q  <= 32'h0;
            maddr_q  <= 32'h0;
            mwdata_q <= 32'h0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (Req) begin
                        off_q    <= Addr[1:0];
                        size_q   <= req_size;
                        signed_q <= Signed;
                        sdata_q  <= StoreData;
                        if (req_err) begin
                            state_q <= ERR;
                        end else begin
                            maddr_q <= {Addr[31:2], 2'b00};
                            if (!IsStore) begin
                                state_q <= LOAD;
                            end else if (req_size == SIZE_WORD) begin
                                state_q  <= ST_WORD;
                                mwdata_q <= StoreData;
                            end else begin
                                state_q <= RMW_RD;
                            end
                        end
                    end
                end
                ERR: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    err_q   <= 1'b1;
                end
                LOAD: begin
                    ldata_q <= load_val;
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                ST_WORD: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                RMW_RD: begin
                    mwdata_q <= merged;
                    state_q  <= RMW_WR;
                end
                RMW_WR: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Ready        = (state_q == IDLE);
    assign Done         = done_q;
    assign Err          = err_q;
    assign LoadData     = ldata_q;
    assign MemAddress   = maddr_q;
    assign MemWriteData = mwdata_q;
    assign MemRead      = ~Reset & ((state_q == LOAD) | (state_q == RMW_RD));
    assign MemWrite     = ~Reset & ((state_q == ST_WORD) | (state_q == RMW_WR));

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 1024-word memory model.
// Table of single requests plus reset-in-RMW and back-to-back sequences.
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req;
    logic        IsStore;
    logic [1:0]  Size;
    logic        Signed;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic        Ready;
    logic        Done;
    logic        Err;
    logic [31:0] LoadData;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemReadData;

    load_store_unit #(.MEM_WORDS(1024), .CHECK_RANGE(1'b1)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Req          (Req),
        .IsStore      (IsStore),
        .Size         (Size),
        .Signed       (Signed),
        .Addr         (Addr),
        .StoreData    (StoreData),
        .Ready        (Ready),
        .Done         (Done),
        .Err          (Err),
        .LoadData     (LoadData),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .MemReadData  (MemReadData)
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem [0:1023] = '{default: 32'h0};

    assign MemReadData = mem[MemAddress[11:2]];

    always @(posedge Clk) begin
        if (MemWrite) mem[MemAddress[11:2]] <= MemWriteData;
    end

    int rd_tot = 0;
    int wr_tot = 0;

    always @(negedge Clk) begin
        if (MemRead)  rd_tot++;
        if (MemWrite) wr_tot++;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic issue(input logic st, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] d);
        Req       = 1'b1;
        IsStore   = st;
        Size      = sz;
        Signed    = sg;
        Addr      = a;
        StoreData = d;
        @(posedge Clk);
        #1;
        Req       = 1'b0;
        IsStore   = 1'b0;
        Size      = 2'b00;
        Addr      = 32'hx;
        StoreData = 32'hx;
    endtask

    task automatic wait_done(output int lat, output logic err);
        logic seen;
        seen = 1'b0;
        lat  = 1;
        err  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!seen) begin
                @(posedge Clk);
                #1;
                lat++;
                if (Done) begin
                    seen = 1'b1;
                    err  = Err;
                end
            end
        end
    endtask

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        logic        err;
        logic [31:0] ld;
        int          rd;
        int          wr;
        logic        chk;
        int          idx;
        logic [31:0] mw;
    } vec_t;

    vec_t vt [16];

    initial begin
        int          lat;
        logic        err;
        int          r0;
        int          w0;
        logic        any_done;

        vt[0]  = '{1, 2'b10, 0, 32'h0,   32'h12345678, 2, 0, 32'h00000000, 0, 1, 1, 0, 32'h12345678};
        vt[1]  = '{0, 2'b10, 0, 32'h0,   32'h0,        2, 0, 32'h12345678, 1, 0, 0, 0, 32'h0};
        vt[2]  = '{1, 2'b10, 0, 32'h4,   32'habcdef98, 2, 0, 32'h12345678, 0, 1, 1, 1, 32'habcdef98};
        vt[3]  = '{1, 2'b00, 0, 32'h5,   32'h000000AB, 3, 0, 32'h12345678, 1, 1, 1, 1, 32'habcdab98};
        vt[4]  = '{0, 2'b01, 1, 32'h6,   32'h0,        2, 0, 32'hFFFFABCD, 1, 0, 0, 0, 32'h0};
        vt[5]  = '{0, 2'b01, 0, 32'h6,   32'h0,        2, 0, 32'h0000ABCD, 1, 0, 0, 0, 32'h0};
        vt[6]  = '{0, 2'b00, 1, 32'h4,   32'h0,        2, 0, 32'hFFFFFF98, 1, 0, 0, 0, 32'h0};
        vt[7]  = '{0, 2'b10, 0, 32'h2,   32'h0,        2, 1, 32'hFFFFFF98, 0, 0, 0, 0, 32'h0};
        vt[8]  = '{1, 2'b01, 0, 32'h1,   32'h00001234, 2, 1, 32'hFFFFFF98, 0, 0, 1, 0, 32'h12345678};
        vt[9]  = '{0, 2'b11, 0, 32'h0,   32'h0,        2, 1, 32'hFFFFFF98, 0, 0, 0, 0, 32'h0};
        vt[10] = '{0, 2'b10, 0, 32'h1000, 32'h0,       2, 1, 32'hFFFFFF98, 0, 0, 0, 0, 32'h0};
        vt[11] = '{0, 2'b00, 0, 32'h7,   32'h0,        2, 0, 32'h000000AB, 1, 0, 0, 0, 32'h0};
        vt[12] = '{1, 2'b01, 0, 32'hE,   32'h00001234, 3, 0, 32'h000000AB, 1, 1, 1, 3, 32'h12340000};
        vt[13] = '{0, 2'b01, 1, 32'hE,   32'h0,        2, 0, 32'h00001234, 1, 0, 0, 0, 32'h0};
        vt[14] = '{0, 2'b10, 0, 32'hFFC, 32'h0,        2, 0, 32'h00000000, 1, 0, 0, 0, 32'h0};
        vt[15] = '{1, 2'b10, 0, 32'h8,   32'hFFFFFFFF, 2, 0, 32'h00000000, 0, 1, 1, 2, 32'hFFFFFFFF};

        Reset     = 1'b1;
        Req       = 1'b0;
        IsStore   = 1'b0;
        Size      = 2'b00;
        Signed    = 1'b0;
        Addr      = 32'h0;
        StoreData = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_memread",  {31'h0, MemRead},  32'h0);
        check("rst_memwrite", {31'h0, MemWrite}, 32'h0);
        Reset = 1'b0;
        #1;
        check("rst_ready",  {31'h0, Ready}, 32'h1);
        check("rst_done",   {31'h0, Done},  32'h0);
        check("rst_err",    {31'h0, Err},   32'h0);
        check("rst_ldata",  LoadData,       32'h0);
        check("rst_maddr",  MemAddress,     32'h0);
        check("rst_mwdata", MemWriteData,   32'h0);

        for (int i = 0; i < 16; i++) begin
            check($sformatf("v%0d ready", i), {31'h0, Ready}, 32'h1);
            r0 = rd_tot;
            w0 = wr_tot;
            issue(vt[i].st, vt[i].sz, vt[i].sg, vt[i].a, vt[i].d);
            wait_done(lat, err);
            check($sformatf("v%0d lat", i), 32'(lat), 32'(vt[i].lat));
            check($sformatf("v%0d err", i), {31'h0, err}, {31'h0, vt[i].err});
            check($sformatf("v%0d ldata", i), LoadData, vt[i].ld);
            check($sformatf("v%0d rd", i), 32'(rd_tot - r0), 32'(vt[i].rd));
            check($sformatf("v%0d wr", i), 32'(wr_tot - w0), 32'(vt[i].wr));
            if (vt[i].chk)
                check($sformatf("v%0d mem", i), mem[vt[i].idx], vt[i].mw);
        end

        // Reset asserted during the RMW write cycle.
        w0 = wr_tot;
        issue(1'b1, 2'b00, 1'b0, 32'h8, 32'h00000055);
        @(posedge Clk);
        #1;
        check("rmwrst_pre_wr", {31'h0, MemWrite}, 32'h1);
        Reset = 1'b1;
        #1;
        check("rmwrst_gated", {31'h0, MemWrite}, 32'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("rmwrst_ready", {31'h0, Ready}, 32'h1);
        check("rmwrst_wr", 32'(wr_tot - w0), 32'h0);
        check("rmwrst_mem", mem[2], 32'hFFFFFFFF);
        any_done = Done;
        repeat (3) begin
            @(posedge Clk);
            #1;
            any_done = any_done | Done;
        end
        check("rmwrst_nodone", {31'h0, any_done}, 32'h0);

        // Back-to-back: load issued in the store's Done cycle.
        issue(1'b1, 2'b10, 1'b0, 32'hC, 32'h00000001);
        @(posedge Clk);
        #1;
        check("b2b_st_done",  {31'h0, Done},  32'h1);
        check("b2b_st_ready", {31'h0, Ready}, 32'h1);
        issue(1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
        check("b2b_accepted", {31'h0, Ready},   32'h0);
        check("b2b_memread",  {31'h0, MemRead}, 32'h1);
        @(posedge Clk);
        #1;
        check("b2b_ld_done", {31'h0, Done}, 32'h1);
        check("b2b_ldata",   LoadData,      32'h00000001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
